// File: rtl/uart_rx_buffer.sv
// Receive-side byte buffer behind the UART receiver: captures {error, data} on rx_done
// into a DEPTH-entry FIFO and presents it first-word-fall-through with ready/valid.
module uart_rx_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic                     rx_error,
    output logic                     rx_full,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_error,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     clear_overrun,
    input  logic                     flush
);
    localparam int AW = $clog2(DEPTH);

    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [8:0]  head;
    logic        empty, full, push, pop, drop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign pop  = !empty && out_ready;
    // A pop frees the slot in the same edge, so a full buffer can still take a byte.
    assign push = rx_done && (!full || pop) && !flush;
    assign drop = rx_done && full && !pop && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            // Setting wins over a coincident clear so no drop goes unreported.
            if (drop)               overrun <= 1'b1;
            else if (clear_overrun) overrun <= 1'b0;
        end
    end

    // Storage is not reset; contents behind the pointers are don't-care.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {rx_error, rx_data};
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : head[7:0];
    assign out_error = empty ? 1'b0  : head[8];
    assign rx_full   = full;
    assign count     = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed scoreboard bench for uart_rx_buffer: inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_uart_rx_buffer;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_error = 1'b0;
    logic       rx_full;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_error;
    logic       out_ready = 1'b0;
    logic [4:0] count;
    logic       overrun;
    logic       clear_overrun = 1'b0;
    logic       flush = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [8:0] sb[$];
    logic       exp_ovr = 1'b0;
    logic [8:0] last;

    uart_rx_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .rx_error(rx_error),
        .rx_full(rx_full), .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
        .out_ready(out_ready), .count(count), .overrun(overrun),
        .clear_overrun(clear_overrun), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(sb.size()));
        chk({tag, "_full"}, 32'(rx_full), 32'(sb.size() == DEPTH));
        chk({tag, "_valid"}, 32'(out_valid), 32'(sb.size() != 0));
        chk({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic chk_head(input string tag);
        if (sb.size() != 0) begin
            chk({tag, "_data"}, 32'(out_data), 32'(sb[0][7:0]));
            chk({tag, "_err"}, 32'(out_error), 32'(sb[0][8]));
        end else begin
            chk({tag, "_data0"}, 32'(out_data), 32'h0);
            chk({tag, "_err0"}, 32'(out_error), 32'h0);
        end
    endtask

    // One cycle with optional push / pop / clear / flush; the model is updated alongside.
    task automatic cyc(input logic d, input logic [7:0] b, input logic e,
                       input logic rdy, input logic clr, input logic fl);
        logic popping;
        chk_head("head");
        popping = rdy && (sb.size() != 0);
        rx_done = d; rx_data = b; rx_error = e;
        out_ready = rdy; clear_overrun = clr; flush = fl;
        @(negedge clk);
        rx_done = 1'b0; out_ready = 1'b0; clear_overrun = 1'b0; flush = 1'b0;
        if (fl) begin
            sb.delete();
            if (clr) exp_ovr = 1'b0;
        end else begin
            logic was_full;
            was_full = (sb.size() == DEPTH);
            if (popping) last = sb.pop_front();
            if (d && (!was_full || popping)) sb.push_back({e, b});
            if (d && was_full && !popping) exp_ovr = 1'b1;
            else if (clr) exp_ovr = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] b, input logic e);
        cyc(1'b1, b, e, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        while (sb.size() != 0) begin
            pop();
            chk_state(tag);
        end
        chk_head({tag, "_empty"});
    endtask

    initial begin
        // Reset values while held in reset
        #1;
        chk_state("reset");
        chk_head("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: single byte latency and pop
        push(8'hA5, 1'b0);
        chk_state("t1_push");
        chk_head("t1_head");
        pop();
        chk_state("t1_pop");
        chk_head("t1_empty");

        // 2: fill, drop, drain in order
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
        chk_state("t2_full");
        push(8'hFF, 1'b0);
        chk_state("t2_drop");
        chk("t2_ovr_set", 32'(overrun), 32'h1);
        pop();
        chk("t2_full_clr", 32'(rx_full), 32'h0);
        drain("t2_drain");
        chk("t2_last", 32'(last), 32'h00F);

        // 3: push+pop when full is accepted without overrun
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_state("t3_clr");
        for (int i = 0; i < DEPTH; i++) push(8'h80 + 8'(i), 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_state("t3_both");
        chk("t3_ovr0", 32'(overrun), 32'h0);
        drain("t3_drain");
        chk("t3_last", 32'(last), 32'h055);

        // 4: error flag travels with its byte
        push(8'h12, 1'b1);
        push(8'h34, 1'b0);
        chk_state("t4_two");
        drain("t4_drain");

        // 5: set wins over clear, then clear alone
        for (int i = 0; i < DEPTH; i++) push(8'(8'hC0 ^ i), 1'b1);
        push(8'hEE, 1'b0);
        chk_state("t5_set");
        cyc(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_state("t5_setwins");
        chk("t5_ovr1", 32'(overrun), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_state("t5_clear");
        chk("t5_ovr0", 32'(overrun), 32'h0);
        drain("t5_drain");

        // 6: flush with coincident rx_done; overrun untouched either way
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
        push(8'hAA, 1'b0);
        chk_state("t6_ovr");
        drain("t6_pre");
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_state("t6_flush");
        chk("t6_ovr_kept", 32'(overrun), 32'h1);
        chk_head("t6_flush");
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i), 1'b0);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_state("t6_flush_full");
        chk("t6_no_set", 32'(overrun), 32'h0);

        // 6b: 40 push/pop pairs across pointer wrap, with a standing occupancy of one
        push(8'h5A, 1'b1);
        for (int i = 0; i < 40; i++) begin
            push(8'($urandom_range(0, 255)), 1'(i % 3 == 0));
            pop();
            chk_state("wrap");
        end
        drain("wrap_drain");

        // 6c: asynchronous reset mid-stream
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        for (int i = 0; i < DEPTH; i++) push(8'h30 + 8'(i), 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        exp_ovr = 1'b0;
        chk_state("rst_mid");
        chk_head("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_state("rst_after");
        push(8'hB7, 1'b0);
        chk_state("rst_push");
        drain("rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
